// File: rtl/navic_pkg.sv
// Shared types and constants for the NavIC pilot chip-timing sequencer.
// Latency: n/a (package only).
// Backpressure: n/a (package only).
package navic_pkg;

  typedef enum logic [1:0] {
    ST_IDLE     = 2'd0,
    ST_LOAD     = 2'd1,
    ST_RUN      = 2'd2,
    ST_STOPPING = 2'd3
  } state_t;

  localparam int CODE_LEN_L1 = 10230;
  localparam int OVL_LEN_L1  = 1800;
  localparam int PRN_MAX     = 14;

  // Legal PRNs are 1..max_prn; 0 is reserved.
  function automatic logic prn_legal(input logic [5:0] prn, input int max_prn);
    return (prn != 6'd0) && (int'(prn) <= max_prn);
  endfunction

endpackage

// File: rtl/navic_chip_timer.sv
// Chip prescaler, chip counter and overlay counter with epoch/frame decode.
// Latency: chip_en/epoch/frame are combinational decodes of registered counters.
// Backpressure: none; ena low freezes every counter and masks every pulse.
module navic_chip_timer
  import navic_pkg::*;
#(
  parameter int CODE_LEN = CODE_LEN_L1,
  parameter int OVL_LEN  = OVL_LEN_L1,
  parameter int DIV_W    = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             ena,
  input  logic             i_clear,
  input  logic             i_active,
  input  logic [DIV_W-1:0] i_div,
  output logic             o_chip_en,
  output logic             o_epoch,
  output logic             o_frame,
  output logic [13:0]      o_chip_idx,
  output logic [10:0]      o_ovl_idx
);

  localparam logic [13:0] LP_CHIP_LAST = 14'(CODE_LEN - 1);
  localparam logic [10:0] LP_OVL_LAST  = 11'(OVL_LEN - 1);

  logic [DIV_W-1:0] r_presc;
  logic [13:0]      r_chip_idx;
  logic [10:0]      r_ovl_idx;
  logic             w_tick;

  assign w_tick     = i_active && (r_presc == i_div);
  assign o_chip_en  = ena && w_tick;
  assign o_epoch    = o_chip_en && (r_chip_idx == LP_CHIP_LAST);
  assign o_frame    = o_epoch && (r_ovl_idx == LP_OVL_LAST);
  assign o_chip_idx = r_chip_idx;
  assign o_ovl_idx  = r_ovl_idx;

  // Counters advance only while active; a clear (load or stop completion) wins over wrap.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_presc    <= '0;
      r_chip_idx <= '0;
      r_ovl_idx  <= '0;
    end else if (ena) begin
      if (i_clear) begin
        r_presc    <= '0;
        r_chip_idx <= '0;
        r_ovl_idx  <= '0;
      end else if (i_active) begin
        r_presc <= w_tick ? '0 : r_presc + 1'b1;
        if (w_tick) begin
          r_chip_idx <= (r_chip_idx == LP_CHIP_LAST) ? 14'd0 : r_chip_idx + 14'd1;
        end
        if (o_epoch) begin
          r_ovl_idx <= (r_ovl_idx == LP_OVL_LAST) ? 11'd0 : r_ovl_idx + 11'd1;
        end
      end
    end
  end

endmodule

// File: rtl/navic_pilot_seq.sv
// NavIC pilot sequencer: config handshake, generator load strobe, chip cadence.
// Latency: gen_load one cycle after start; first chip_en div+1 cycles after gen_load.
// Backpressure: cfg_ready high only in IDLE; requester holds cfg_valid until accepted.
module navic_pilot_seq
  import navic_pkg::*;
#(
  parameter int CODE_LEN = CODE_LEN_L1,
  parameter int OVL_LEN  = OVL_LEN_L1,
  parameter int PRN_MAX  = navic_pkg::PRN_MAX,
  parameter int DIV_W    = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             ena,
  input  logic             cfg_valid,
  output logic             cfg_ready,
  input  logic [5:0]       cfg_prn,
  input  logic [DIV_W-1:0] cfg_div,
  output logic             cfg_err,
  input  logic             start,
  input  logic             stop,
  output logic [5:0]       gen_prn,
  output logic             gen_load,
  output logic             gen_chip_en,
  output logic [13:0]      chip_idx,
  output logic [10:0]      ovl_idx,
  output logic             epoch,
  output logic             frame,
  output logic             busy
);

  state_t           r_state;
  state_t           w_state_nxt;
  logic [5:0]       r_prn;
  logic [DIV_W-1:0] r_div;
  logic             r_cfg_err;
  logic             w_cfg_hs;
  logic             w_prn_ok;
  logic             w_clear;
  logic             w_active;
  logic             w_epoch;

  assign w_cfg_hs = ena && cfg_valid && (r_state == ST_IDLE);
  assign w_prn_ok = prn_legal(cfg_prn, PRN_MAX);
  assign gen_prn  = r_prn;
  assign cfg_err  = r_cfg_err && ena;
  assign epoch    = w_epoch;

  // Config registers: a legal PRN replaces prn/div; an illegal one only raises the error pulse.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_prn     <= 6'd1;
      r_div     <= '0;
      r_cfg_err <= 1'b0;
    end else if (ena) begin
      r_cfg_err <= w_cfg_hs && !w_prn_ok;
      if (w_cfg_hs && w_prn_ok) begin
        r_prn <= cfg_prn;
        r_div <= cfg_div;
      end
    end
  end

  // State register; frozen while ena is low.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state <= ST_IDLE;
    end else if (ena) begin
      r_state <= w_state_nxt;
    end
  end

  // Next state plus decoded controls; the epoch that ends a stop also clears the counters.
  always_comb begin
    w_state_nxt = r_state;
    w_clear     = 1'b0;
    w_active    = 1'b0;
    gen_load    = 1'b0;
    cfg_ready   = (r_state == ST_IDLE);
    busy        = (r_state != ST_IDLE);
    case (r_state)
      ST_IDLE: begin
        if (start) w_state_nxt = ST_LOAD;
      end
      ST_LOAD: begin
        gen_load    = ena;
        w_clear     = 1'b1;
        w_state_nxt = ST_RUN;
      end
      ST_RUN: begin
        w_active = 1'b1;
        if (stop && w_epoch) begin
          w_state_nxt = ST_IDLE;
          w_clear     = 1'b1;
        end else if (stop) begin
          w_state_nxt = ST_STOPPING;
        end
      end
      ST_STOPPING: begin
        w_active = 1'b1;
        if (w_epoch) begin
          w_state_nxt = ST_IDLE;
          w_clear     = 1'b1;
        end
      end
      default: w_state_nxt = ST_IDLE;
    endcase
  end

  navic_chip_timer #(
    .CODE_LEN (CODE_LEN),
    .OVL_LEN  (OVL_LEN),
    .DIV_W    (DIV_W)
  ) u_timer (
    .clk        (clk),
    .rst        (rst),
    .ena        (ena),
    .i_clear    (w_clear),
    .i_active   (w_active),
    .i_div      (r_div),
    .o_chip_en  (gen_chip_en),
    .o_epoch    (w_epoch),
    .o_frame    (frame),
    .o_chip_idx (chip_idx),
    .o_ovl_idx  (ovl_idx)
  );

endmodule

// File: tb/tb_navic_pilot_seq.sv
// Directed bench for navic_pilot_seq with shortened code/overlay lengths.
// Latency: checks sampled 1 time unit after each rising edge.
// Backpressure: every wait on the DUT is bounded by a cycle budget.
module tb_navic_pilot_seq;

  logic        clk = 1'b0;
  logic        rst, ena, cfg_valid, start, stop;
  logic [5:0]  cfg_prn;
  logic [7:0]  cfg_div;
  logic        cfg_ready, cfg_err, gen_load, gen_chip_en, epoch, frame, busy;
  logic [5:0]  gen_prn;
  logic [13:0] chip_idx;
  logic [10:0] ovl_idx;

  int n_checks = 0;
  int n_errors = 0;
  int exp_q[$];

  navic_pilot_seq #(.CODE_LEN(16), .OVL_LEN(3), .PRN_MAX(14), .DIV_W(8)) dut (
    .clk(clk), .rst(rst), .ena(ena),
    .cfg_valid(cfg_valid), .cfg_ready(cfg_ready), .cfg_prn(cfg_prn), .cfg_div(cfg_div),
    .cfg_err(cfg_err), .start(start), .stop(stop),
    .gen_prn(gen_prn), .gen_load(gen_load), .gen_chip_en(gen_chip_en),
    .chip_idx(chip_idx), .ovl_idx(ovl_idx), .epoch(epoch), .frame(frame), .busy(busy)
  );

  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_errors++;
      $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  task automatic check_q(input string tag, input logic [31:0] obs);
    int e;
    if (exp_q.size() == 0) begin
      n_checks++;
      n_errors++;
      $error("FAIL %s observed=%0d expected=<empty scoreboard>", tag, obs);
    end else begin
      e = exp_q.pop_front();
      check(tag, obs, e);
    end
  endtask

  // s: 0 gen_load, 1 gen_chip_en, 2 epoch, 3 frame, >=100 chip_idx == s-100
  function automatic logic sel_sig(input int s);
    if (s == 0) return gen_load;
    if (s == 1) return gen_chip_en;
    if (s == 2) return epoch;
    if (s == 3) return frame;
    return (chip_idx == 14'(s - 100));
  endfunction

  task automatic wait_for(input int s, input int max_cyc, input string tag, output int n);
    n = 0;
    while (!sel_sig(s) && n < max_cyc) begin
      tick();
      n++;
    end
    check(tag, 32'(sel_sig(s)), 32'd1);
  endtask

  initial begin
    int n;
    rst = 1'b1; ena = 1'b1; cfg_valid = 1'b0; start = 1'b0; stop = 1'b0;
    cfg_prn = 6'd0; cfg_div = 8'd0;
    tick();
    tick();
    check("rst_cfg_ready", 32'(cfg_ready), 1);
    check("rst_busy", 32'(busy), 0);
    check("rst_gen_prn", 32'(gen_prn), 1);
    check("rst_chip_idx", 32'(chip_idx), 0);
    check("rst_gen_load", 32'(gen_load), 0);
    rst = 1'b0;
    tick();

    // Config prn=5 div=3 together with start.
    cfg_valid = 1'b1; cfg_prn = 6'd5; cfg_div = 8'd3; start = 1'b1;
    exp_q.push_back(5);
    exp_q.push_back(4);
    exp_q.push_back(4);
    tick();
    cfg_valid = 1'b0; start = 1'b0;
    check("load_cfg_ready", 32'(cfg_ready), 0);
    check("load_strobe", 32'(gen_load), 1);
    check_q("load_gen_prn", 32'(gen_prn));
    tick();
    check("load_one_cycle", 32'(gen_load), 0);
    wait_for(1, 20, "first_chip_en", n);
    check_q("first_chip_en_delay", 32'(n + 1));
    tick();
    wait_for(1, 20, "second_chip_en", n);
    check_q("chip_en_period", 32'(n + 1));

    // Graceful stop requested at chip 7.
    wait_for(107, 100, "reach_chip7", n);
    stop = 1'b1;
    tick();
    stop = 1'b0;
    check("stopping_busy", 32'(busy), 1);
    exp_q.push_back(15);
    wait_for(2, 100, "stop_epoch", n);
    check_q("stop_epoch_chip", 32'(chip_idx));
    tick();
    check("stop_idle_busy", 32'(busy), 0);
    check("stop_idle_ready", 32'(cfg_ready), 1);
    check("stop_chip_clr", 32'(chip_idx), 0);
    check("stop_ovl_clr", 32'(ovl_idx), 0);

    // div=0: epoch every 16 clocks, frame on third epoch.
    cfg_valid = 1'b1; cfg_prn = 6'd2; cfg_div = 8'd0; start = 1'b1;
    tick();
    cfg_valid = 1'b0; start = 1'b0;
    for (int k = 0; k < 3; k++) begin
      exp_q.push_back(16);
      exp_q.push_back(k);
      exp_q.push_back(k == 2 ? 1 : 0);
    end
    for (int k = 0; k < 3; k++) begin
      if (k > 0) tick();
      wait_for(2, 40, "epoch_arrive", n);
      check_q("epoch_gap", 32'(n + ((k > 0) ? 1 : 0)));
      check("epoch_chip15", 32'(chip_idx), 15);
      check_q("epoch_ovl_idx", 32'(ovl_idx));
      check_q("epoch_frame", 32'(frame));
    end
    tick();
    check("ovl_wrap", 32'(ovl_idx), 0);
    check("chip_wrap", 32'(chip_idx), 0);

    // ena low for 10 cycles freezes everything.
    wait_for(104, 40, "reach_chip4", n);
    ena = 1'b0;
    for (int k = 0; k < 10; k++) begin
      tick();
      check("frozen_chip_idx", 32'(chip_idx), 4);
      check("frozen_no_chip_en", 32'(gen_chip_en), 0);
    end
    ena = 1'b1;
    #1;
    check("resume_chip_en", 32'(gen_chip_en), 1);
    tick();
    check("resume_chip_idx", 32'(chip_idx), 5);

    // Reset mid-run at chip 9.
    wait_for(109, 40, "reach_chip9", n);
    #2 rst = 1'b1;
    #1;
    check("arst_chip_idx", 32'(chip_idx), 0);
    check("arst_busy", 32'(busy), 0);
    check("arst_gen_prn", 32'(gen_prn), 1);
    check("arst_chip_en", 32'(gen_chip_en), 0);
    tick();
    rst = 1'b0;
    tick();
    start = 1'b1;
    exp_q.push_back(1);
    tick();
    start = 1'b0;
    check("post_rst_load", 32'(gen_load), 1);
    check("post_rst_prn", 32'(gen_prn), 1);
    wait_for(1, 20, "post_rst_chip_en", n);
    check_q("post_rst_div0", 32'(n));

    // stop coincident with an epoch goes straight to IDLE.
    wait_for(2, 40, "coinc_epoch", n);
    stop = 1'b1;
    tick();
    stop = 1'b0;
    check("coinc_idle", 32'(busy), 0);
    check("coinc_chip_clr", 32'(chip_idx), 0);

    // Illegal PRNs 0 and 15, then legal 14.
    cfg_valid = 1'b1; cfg_prn = 6'd0; cfg_div = 8'd5;
    tick();
    cfg_valid = 1'b0;
    check("err_prn0_pulse", 32'(cfg_err), 1);
    tick();
    check("err_prn0_clear", 32'(cfg_err), 0);
    cfg_valid = 1'b1; cfg_prn = 6'd15; cfg_div = 8'd5;
    tick();
    cfg_valid = 1'b0;
    check("err_prn15_pulse", 32'(cfg_err), 1);
    check("err_prn_kept", 32'(gen_prn), 1);
    tick();
    cfg_valid = 1'b1; cfg_prn = 6'd14; cfg_div = 8'd0;
    tick();
    cfg_valid = 1'b0;
    check("prn14_no_err", 32'(cfg_err), 0);
    check("prn14_accept", 32'(gen_prn), 14);
    start = 1'b1;
    tick();
    start = 1'b0;
    wait_for(1, 20, "prn14_chip_en", n);
    check("prn14_div_kept", 32'(n), 1);

    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

endmodule

// File: doc/navic_pilot_seq.md
Name: navic_pilot_seq

Overview:
- Chip-timing sequencer and configuration controller for the NavIC pilot code generator datapath.
- Accepts a PRN/chip-rate configuration over a valid/ready handshake, issues the generator load strobe, and produces the chip-enable cadence.
- Counts chips per primary-code period and epochs per overlay period.
- Drives the generator core and downstream correlator/test logic from the top-level wrapper.

Parameters:
- CODE_LEN, 10230: chips per primary code period.
- OVL_LEN, 1800: primary epochs per overlay (secondary) code period.
- PRN_MAX, 14: highest legal PRN; legal range is 1..PRN_MAX.
- DIV_W, 8: width of chip-rate divider field.

Ports:
- clk, in, 1: system clock.
- rst, in, 1: reset, asynchronous, active-high.
- ena, in, 1: global enable; when low all state and counters hold.
- cfg_valid, in, 1: configuration offered.
- cfg_ready, out, 1: configuration accepted; high only in IDLE.
- cfg_prn, in, 6: requested PRN.
- cfg_div, in, DIV_W: a chip is produced every cfg_div+1 clocks.
- cfg_err, out, 1: one-cycle pulse when an illegal PRN is handshaken.
- start, in, 1: begin generation.
- stop, in, 1: request graceful stop.
- gen_prn, out, 6: active PRN to the generator.
- gen_load, out, 1: one-cycle strobe to load the generator initial state.
- gen_chip_en, out, 1: advance the generator by one chip.
- chip_idx, out, 14: index of the current chip, 0..CODE_LEN-1.
- ovl_idx, out, 11: current overlay bit index, 0..OVL_LEN-1.
- epoch, out, 1: pulse coincident with the last chip of a code period.
- frame, out, 1: pulse coincident with the last chip of an overlay period.
- busy, out, 1: high in any state other than IDLE.

Behaviour:
- Reset values: prn_r=1, div_r=0, prescaler=0, chip_idx=0, ovl_idx=0, state=IDLE. All pulse outputs are 0, busy=0, cfg_ready=1, gen_prn=1.
- FSM states: IDLE, LOAD, RUN, STOPPING. Encoding lives in the shared package.
- ena=0 freezes all registers. Pulses, including gen_load, are suppressed while ena=0. Reset still acts immediately.
- cfg_ready = (state==IDLE).
- Config handshake: cfg_valid & cfg_ready at a clock edge completes the handshake.
  - PRN legal (1..PRN_MAX): prn_r<=cfg_prn, div_r<=cfg_div.
  - PRN illegal (0 or >PRN_MAX): prn_r/div_r unchanged; cfg_err pulses the next cycle.
- IDLE -> LOAD on start.
  - Config accepted on the same edge is the config used.
  - With no prior config, the reset values are used.
- LOAD (1 cycle):
  - gen_load=1; prescaler, chip_idx and ovl_idx cleared.
  - Moves to RUN next cycle.
- RUN:
  - Prescaler counts 0..div_r and wraps.
  - gen_chip_en = (state in RUN/STOPPING) && prescaler==div_r. This is a combinational decode of registers.
  - With div_r=0, gen_chip_en is high every RUN cycle.
  - The first chip_en falls div_r+1 cycles after gen_load.
- Chip counter: on gen_chip_en, chip_idx increments; from CODE_LEN-1 it wraps to 0.
- epoch = gen_chip_en && chip_idx==CODE_LEN-1.
- Overlay counter: on epoch, ovl_idx increments; from OVL_LEN-1 it wraps to 0.
- frame = epoch && ovl_idx==OVL_LEN-1.
- Stop handling:
  - stop in RUN -> STOPPING. Chipping continues unchanged.
  - In STOPPING, the first epoch returns the FSM to IDLE on that edge; chip_idx, ovl_idx and prescaler clear.
  - stop coincident with epoch in RUN: that epoch completes the period; go directly to IDLE.
  - stop in IDLE/LOAD ignored.
- Ignored inputs:
  - start outside IDLE is ignored; there is no restart mid-run.
  - cfg_valid outside IDLE is not accepted; the requester holds it.
- gen_prn = prn_r. It is stable throughout LOAD/RUN/STOPPING because config is only accepted in IDLE.
- Reset mid-run: all outputs return to reset values asynchronously; no pending stop or config survives.

Decomposition:
- Package navic_pkg holds:
  - the state enum;
  - CODE_LEN_L1=10230, OVL_LEN_L1=1800, PRN_MAX=14;
  - a prn_legal() function.
- One natural sub-module: navic_chip_timer, holding the prescaler, chip counter and overlay counter with the epoch/frame decode.
- The FSM and config handshake stay in the parent.

Test Plan:
- Reset then cfg prn=5, div=3, start → cfg_ready drops; gen_load 1 cycle; gen_prn=5; first gen_chip_en 4 cycles after gen_load, then every 4 clocks.
- div=0, CODE_LEN overridden to 16, OVL_LEN to 3 → epoch at chip_idx 15 every 16 clocks; frame on the 3rd epoch; ovl_idx 0→1→2→0.
- cfg prn=0, then prn=15 → cfg_err pulses twice; gen_prn stays 1. A following cfg prn=14 → accepted, no err.
- stop asserted at chip_idx=7 (CODE_LEN=16) → chipping continues; IDLE entered on the edge after the epoch at chip_idx 15; busy=0; counters 0.
- ena low for 10 cycles mid-run → chip_idx/prescaler frozen; no pulses; resumes exactly where held.
- rst asserted at chip_idx=9 in RUN → all outputs reset immediately. start after release uses the last accepted config? No: reset value prn=1, div=0.
